// File: rtl/cirno9_sram_arb.sv
// cirno9_sram_arb
//
// Shares one single-port synchronous SRAM between three requesters:
//   if - instruction fetch
//   ls - execute-stage load/store
//   ax - AXI-slave bridge
//
// One request is granted per cycle, picked combinationally from the valid
// requesters. Base priority is ls > if > ax. Fetch and AXI each carry an aging
// counter, and a requester whose counter has saturated at STARVE_MAX becomes
// urgent and jumps ahead of ls (urgent ax > urgent if). The granted request
// drives the SRAM pins in the same cycle. Read data comes back one cycle later
// and is steered to the requester that issued the read.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   hs_X4arb_val / hs_arb4X_rdy   request valid / grant (X = if, ls, ax)
//   i_X_adr, i_X_wdat             word address, write data
//   i_X_wen, i_X_ren              byte write enables, read enable
//   o_X_rsp_val, o_X_rdat         read response (rdat is 0 unless rsp_val)
//   o_sram_ren, o_sram_wen        SRAM read strobe, byte write strobes
//   o_sram_adr, o_sram_wdat       SRAM address, write data
//   i_sram_rdat                   SRAM read data, one cycle after o_sram_ren
//   o_err                         pulses on a granted request with ren=1 and wen!=0
//
// Sequencing state
//   armed_q | meaning
//   --------+-------------------------------------------------------------
//   0       | first cycle after reset release, grants are held off
//   1       | normal arbitration
module cirno9_sram_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              hs_if4arb_val,
    output logic              hs_arb4if_rdy,
    input  logic [AW-1:0]     i_if_adr,
    input  logic [DW-1:0]     i_if_wdat,
    input  logic [DW/8-1:0]   i_if_wen,
    input  logic              i_if_ren,
    output logic              o_if_rsp_val,
    output logic [DW-1:0]     o_if_rdat,

    input  logic              hs_ls4arb_val,
    output logic              hs_arb4ls_rdy,
    input  logic [AW-1:0]     i_ls_adr,
    input  logic [DW-1:0]     i_ls_wdat,
    input  logic [DW/8-1:0]   i_ls_wen,
    input  logic              i_ls_ren,
    output logic              o_ls_rsp_val,
    output logic [DW-1:0]     o_ls_rdat,

    input  logic              hs_ax4arb_val,
    output logic              hs_arb4ax_rdy,
    input  logic [AW-1:0]     i_ax_adr,
    input  logic [DW-1:0]     i_ax_wdat,
    input  logic [DW/8-1:0]   i_ax_wen,
    input  logic              i_ax_ren,
    output logic              o_ax_rsp_val,
    output logic [DW-1:0]     o_ax_rdat,

    output logic              o_sram_ren,
    output logic [DW/8-1:0]   o_sram_wen,
    output logic [AW-1:0]     o_sram_adr,
    output logic [DW-1:0]     o_sram_wdat,
    input  logic [DW-1:0]     i_sram_rdat,

    output logic              o_err
);

    localparam logic [7:0] STARVE_CNT = 8'(STARVE_MAX);

    // Requester id; the encoding doubles as the 2-bit response owner tag.
    typedef enum logic [1:0] {
        REQ_IF   = 2'd0,
        REQ_LS   = 2'd1,
        REQ_AX   = 2'd2,
        REQ_NONE = 2'd3
    } req_e;

    logic        armed_q, armed_d;
    logic [7:0]  wait_if_q, wait_if_d;
    logic [7:0]  wait_ax_q, wait_ax_d;
    logic        rsp_pend_q, rsp_pend_d;
    req_e        rsp_own_q, rsp_own_d;

    logic        urgent_if;
    logic        urgent_ax;
    req_e        gnt_sel;

    logic [AW-1:0]   sel_adr;
    logic [DW-1:0]   sel_wdat;
    logic [DW/8-1:0] sel_wen;
    logic            sel_ren;
    logic            sel_wr;
    logic            rd_gnt;

    assign urgent_if = (wait_if_q == STARVE_CNT);
    assign urgent_ax = (wait_ax_q == STARVE_CNT);

    // Grant selection.
    always_comb begin
        gnt_sel = REQ_NONE;
        if (armed_q) begin
            if (hs_ax4arb_val && urgent_ax) begin
                gnt_sel = REQ_AX;
            end else if (hs_if4arb_val && urgent_if) begin
                gnt_sel = REQ_IF;
            end else if (hs_ls4arb_val) begin
                gnt_sel = REQ_LS;
            end else if (hs_if4arb_val) begin
                gnt_sel = REQ_IF;
            end else if (hs_ax4arb_val) begin
                gnt_sel = REQ_AX;
            end
        end
    end

    assign hs_arb4if_rdy = (gnt_sel == REQ_IF);
    assign hs_arb4ls_rdy = (gnt_sel == REQ_LS);
    assign hs_arb4ax_rdy = (gnt_sel == REQ_AX);

    // Request mux onto the SRAM pins; all-zero when nothing is granted.
    always_comb begin
        sel_adr  = '0;
        sel_wdat = '0;
        sel_wen  = '0;
        sel_ren  = 1'b0;
        case (gnt_sel)
            REQ_IF: begin
                sel_adr  = i_if_adr;
                sel_wdat = i_if_wdat;
                sel_wen  = i_if_wen;
                sel_ren  = i_if_ren;
            end
            REQ_LS: begin
                sel_adr  = i_ls_adr;
                sel_wdat = i_ls_wdat;
                sel_wen  = i_ls_wen;
                sel_ren  = i_ls_ren;
            end
            REQ_AX: begin
                sel_adr  = i_ax_adr;
                sel_wdat = i_ax_wdat;
                sel_wen  = i_ax_wen;
                sel_ren  = i_ax_ren;
            end
            default: begin
            end
        endcase
    end

    // A request asking for both read and write is carried out as a write only
    // and flagged; the read half is dropped, so no response follows.
    assign sel_wr = |sel_wen;
    assign rd_gnt = sel_ren && !sel_wr;

    assign o_sram_adr  = sel_adr;
    assign o_sram_wdat = sel_wdat;
    assign o_sram_wen  = sel_wen;
    assign o_sram_ren  = rd_gnt;
    assign o_err       = sel_ren && sel_wr;

    // Aging: count lost cycles while valid, saturate, clear on grant or on val low.
    always_comb begin
        wait_if_d = wait_if_q;
        if (!hs_if4arb_val || (gnt_sel == REQ_IF)) begin
            wait_if_d = '0;
        end else if (wait_if_q < STARVE_CNT) begin
            wait_if_d = wait_if_q + 8'd1;
        end

        wait_ax_d = wait_ax_q;
        if (!hs_ax4arb_val || (gnt_sel == REQ_AX)) begin
            wait_ax_d = '0;
        end else if (wait_ax_q < STARVE_CNT) begin
            wait_ax_d = wait_ax_q + 8'd1;
        end
    end

    // Response tracking: exactly one cycle of latency, so a single pending
    // slot suffices even with back-to-back reads from different requesters.
    always_comb begin
        armed_d    = 1'b1;
        rsp_pend_d = rd_gnt;
        rsp_own_d  = rsp_own_q;
        if (rd_gnt) begin
            rsp_own_d = gnt_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q    <= 1'b0;
            wait_if_q  <= '0;
            wait_ax_q  <= '0;
            rsp_pend_q <= 1'b0;
            rsp_own_q  <= REQ_IF;
        end else begin
            armed_q    <= armed_d;
            wait_if_q  <= wait_if_d;
            wait_ax_q  <= wait_ax_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_own_q  <= rsp_own_d;
        end
    end

    assign o_if_rsp_val = rsp_pend_q && (rsp_own_q == REQ_IF);
    assign o_ls_rsp_val = rsp_pend_q && (rsp_own_q == REQ_LS);
    assign o_ax_rsp_val = rsp_pend_q && (rsp_own_q == REQ_AX);

    assign o_if_rdat = o_if_rsp_val ? i_sram_rdat : '0;
    assign o_ls_rdat = o_ls_rsp_val ? i_sram_rdat : '0;
    assign o_ax_rdat = o_ax_rsp_val ? i_sram_rdat : '0;

endmodule

// File: tb/tb_cirno9_sram_arb.sv
// Bench for cirno9_sram_arb. Two instances share the stimulus: instance 0 uses
// STARVE_MAX=8, instance 1 uses STARVE_MAX=2. Each has its own SRAM model and
// its own behavioural reference model, checked on every falling edge.
module tb_cirno9_sram_arb;

    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst_n;

    logic        val  [3];
    logic [31:0] adr  [3];
    logic [31:0] wdat [3];
    logic [3:0]  wen  [3];
    logic        ren  [3];

    logic        rdy_o      [NI][3];
    logic        rsp_val_o  [NI][3];
    logic [31:0] rdat_o     [NI][3];
    logic        sram_ren_o [NI];
    logic [3:0]  sram_wen_o [NI];
    logic [31:0] sram_adr_o [NI];
    logic [31:0] sram_wdat_o[NI];
    logic [31:0] sram_rdat_i[NI];
    logic        err_o      [NI];

    int n_assert = 0;
    int n_fail   = 0;

    int exp_seq [10] = '{1, 1, 2, 0, 1, 2, 0, 1, 2, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        cirno9_sram_arb #(
            .AW(32), .DW(32), .STARVE_MAX(g == 0 ? 8 : 2)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .hs_if4arb_val(val[0]),
            .hs_arb4if_rdy(rdy_o[g][0]),
            .i_if_adr     (adr[0]),
            .i_if_wdat    (wdat[0]),
            .i_if_wen     (wen[0]),
            .i_if_ren     (ren[0]),
            .o_if_rsp_val (rsp_val_o[g][0]),
            .o_if_rdat    (rdat_o[g][0]),
            .hs_ls4arb_val(val[1]),
            .hs_arb4ls_rdy(rdy_o[g][1]),
            .i_ls_adr     (adr[1]),
            .i_ls_wdat    (wdat[1]),
            .i_ls_wen     (wen[1]),
            .i_ls_ren     (ren[1]),
            .o_ls_rsp_val (rsp_val_o[g][1]),
            .o_ls_rdat    (rdat_o[g][1]),
            .hs_ax4arb_val(val[2]),
            .hs_arb4ax_rdy(rdy_o[g][2]),
            .i_ax_adr     (adr[2]),
            .i_ax_wdat    (wdat[2]),
            .i_ax_wen     (wen[2]),
            .i_ax_ren     (ren[2]),
            .o_ax_rsp_val (rsp_val_o[g][2]),
            .o_ax_rdat    (rdat_o[g][2]),
            .o_sram_ren   (sram_ren_o[g]),
            .o_sram_wen   (sram_wen_o[g]),
            .o_sram_adr   (sram_adr_o[g]),
            .o_sram_wdat  (sram_wdat_o[g]),
            .i_sram_rdat  (sram_rdat_i[g]),
            .o_err        (err_o[g])
        );
    end

    function automatic int sm_of(input int g);
        return (g == 0) ? 8 : 2;
    endfunction

    function automatic string rn(input int r);
        if (r == 0) return "if";
        if (r == 1) return "ls";
        return "ax";
    endfunction

    // 0x10 holds a recognisable word; 0x20 starts at zero.
    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hDEADBEEF;
        if (i == 32) return 32'h0;
        return {8'hA5, 8'(i), 8'h5A, 8'(i)};
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM models (one per instance) ----------------
    logic [31:0] s_mem [NI][256];
    logic        l_ren [NI];
    logic [3:0]  l_wen [NI];
    logic [31:0] l_adr [NI];
    logic [31:0] l_wdat[NI];

    initial begin
        for (int g = 0; g < NI; g++) begin
            for (int i = 0; i < 256; i++) s_mem[g][i] = init_word(i);
            sram_rdat_i[g] = 32'h0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                l_ren[g]  = sram_ren_o[g];
                l_wen[g]  = sram_wen_o[g];
                l_adr[g]  = sram_adr_o[g];
                l_wdat[g] = sram_wdat_o[g];
            end
            @(posedge clk);
            for (int g = 0; g < NI; g++) begin
                if (l_wen[g] != 4'h0)
                    s_mem[g][l_adr[g][7:0]] = merge_be(s_mem[g][l_adr[g][7:0]], l_wdat[g], l_wen[g]);
                if (l_ren[g])
                    sram_rdat_i[g] = s_mem[g][l_adr[g][7:0]];
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    int          m_wait_if [NI];
    int          m_wait_ax [NI];
    bit          m_armed   [NI];
    int          m_pend    [NI];
    logic [31:0] m_pend_dat[NI];
    logic [31:0] m_mem     [NI][256];

    task automatic model_cycle(input int g);
        int          sm;
        int          win;
        logic [31:0] e_adr, e_wdat;
        logic [3:0]  e_wen;
        logic        e_ren, e_err;
        string       p;
        sm  = sm_of(g);
        p   = $sformatf("i%0d_", g);
        win = -1;
        if (rst_n && m_armed[g]) begin
            if      (val[2] && m_wait_ax[g] == sm) win = 2;
            else if (val[0] && m_wait_if[g] == sm) win = 0;
            else if (val[1]) win = 1;
            else if (val[0]) win = 0;
            else if (val[2]) win = 2;
        end
        e_adr = 32'h0; e_wdat = 32'h0; e_wen = 4'h0; e_ren = 1'b0; e_err = 1'b0;
        if (win >= 0) begin
            e_adr  = adr[win];
            e_wdat = wdat[win];
            e_wen  = wen[win];
            e_ren  = ren[win] && (wen[win] == 4'h0);
            e_err  = ren[win] && (wen[win] != 4'h0);
        end
        for (int r = 0; r < 3; r++) begin
            chk({p, "rdy_", rn(r)}, 32'(rdy_o[g][r]), 32'(win == r));
            chk({p, "rsp_val_", rn(r)}, 32'(rsp_val_o[g][r]), 32'(rst_n && m_pend[g] == r));
            chk({p, "rdat_", rn(r)}, rdat_o[g][r], (rst_n && m_pend[g] == r) ? m_pend_dat[g] : 32'h0);
        end
        chk({p, "sram_ren"},  32'(sram_ren_o[g]), 32'(e_ren));
        chk({p, "sram_wen"},  32'(sram_wen_o[g]), 32'(e_wen));
        chk({p, "sram_adr"},  sram_adr_o[g], e_adr);
        chk({p, "sram_wdat"}, sram_wdat_o[g], e_wdat);
        chk({p, "err"},       32'(err_o[g]), 32'(e_err));

        if (!rst_n) begin
            m_armed[g] = 1'b0; m_wait_if[g] = 0; m_wait_ax[g] = 0; m_pend[g] = -1;
        end else begin
            m_pend[g] = -1;
            if (win >= 0) begin
                if (wen[win] != 4'h0)
                    m_mem[g][adr[win][7:0]] = merge_be(m_mem[g][adr[win][7:0]], wdat[win], wen[win]);
                else if (ren[win]) begin
                    m_pend[g]     = win;
                    m_pend_dat[g] = m_mem[g][adr[win][7:0]];
                end
            end
            if (!val[0] || win == 0) m_wait_if[g] = 0;
            else if (m_wait_if[g] < sm) m_wait_if[g]++;
            if (!val[2] || win == 2) m_wait_ax[g] = 0;
            else if (m_wait_ax[g] < sm) m_wait_ax[g]++;
            m_armed[g] = 1'b1;
        end
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            m_armed[g] = 1'b0; m_wait_if[g] = 0; m_wait_ax[g] = 0;
            m_pend[g] = -1; m_pend_dat[g] = 32'h0;
            for (int i = 0; i < 256; i++) m_mem[g][i] = init_word(i);
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) model_cycle(g);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_req(input int r, input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic rd);
        val[r] = v; adr[r] = a; wdat[r] = d; wen[r] = be; ren[r] = rd;
    endtask

    task automatic idle_all();
        for (int r = 0; r < 3; r++) set_req(r, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic to_sample();
        @(negedge clk); #1;
    endtask

    task automatic to_drive();
        @(posedge clk); #1;
    endtask

    function automatic int winner(input int g);
        int w;
        w = -1;
        for (int r = 0; r < 3; r++) begin
            if (rdy_o[g][r]) w = (w == -1) ? r : 9;
        end
        return w;
    endfunction

    int first0, first1, ls_after;

    initial begin
        rst_n = 1'b1;
        set_req(0, 1'b1, 32'h1,  32'h0, 4'h0, 1'b1);
        set_req(1, 1'b1, 32'h10, 32'h0, 4'h0, 1'b1);
        set_req(2, 1'b1, 32'h2,  32'h0, 4'h0, 1'b1);
        #1 rst_n = 1'b0;
        to_drive();
        to_drive();

        // Reset release: held off for one cycle, then ls wins.
        rst_n = 1'b1;
        to_sample();
        for (int g = 0; g < NI; g++) chk($sformatf("i%0d_unarmed_no_rdy", g), winner(g), -1);
        to_drive();
        to_sample();
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("i%0d_first_gnt_ls", g), winner(g), 1);
            chk($sformatf("i%0d_first_sram_adr", g), sram_adr_o[g], 32'h10);
            chk($sformatf("i%0d_first_sram_ren", g), 32'(sram_ren_o[g]), 1);
        end
        to_drive();
        idle_all();
        to_sample();
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("i%0d_ls_rsp_val", g), 32'(rsp_val_o[g][1]), 1);
            chk($sformatf("i%0d_ls_rdat", g), rdat_o[g][1], 32'hDEADBEEF);
            chk($sformatf("i%0d_if_rsp_quiet", g), 32'(rsp_val_o[g][0]), 0);
            chk($sformatf("i%0d_ax_rsp_quiet", g), 32'(rsp_val_o[g][2]), 0);
            chk($sformatf("i%0d_ax_rdat_zero", g), rdat_o[g][2], 0);
        end
        to_drive();

        // ls hogging, ax ages to urgency.
        set_req(1, 1'b1, 32'h30, 32'h30303030, 4'hF, 1'b0);
        set_req(2, 1'b1, 32'h10, 32'h0, 4'h0, 1'b1);
        first0 = 0; first1 = 0; ls_after = 0;
        for (int n = 1; n <= 12; n++) begin
            to_sample();
            if (first0 == 0 && rdy_o[0][2]) first0 = n;
            if (first1 == 0 && rdy_o[1][2]) first1 = n;
            if (n == 10) ls_after = int'(rdy_o[0][1]);
            to_drive();
        end
        chk("ax_urgent_cycle_sm8", first0, 9);
        chk("ax_urgent_cycle_sm2", first1, 3);
        chk("ls_resumes_after_ax", ls_after, 1);
        idle_all();
        to_drive();

        // All three continuously valid on the STARVE_MAX=2 instance.
        set_req(0, 1'b1, 32'h1, 32'h0, 4'h0, 1'b1);
        set_req(1, 1'b1, 32'h2, 32'h0, 4'h0, 1'b1);
        set_req(2, 1'b1, 32'h3, 32'h0, 4'h0, 1'b1);
        for (int n = 0; n < 10; n++) begin
            to_sample();
            chk($sformatf("sm2_grant_seq_%0d", n), winner(1), exp_seq[n]);
            to_drive();
        end
        idle_all();
        to_drive();

        // Byte write then read-after-write from another requester.
        set_req(0, 1'b1, 32'h20, 32'h0000000F, 4'b0001, 1'b0);
        to_sample();
        for (int g = 0; g < NI; g++) chk($sformatf("i%0d_if_wr_gnt", g), winner(g), 0);
        to_drive();
        idle_all();
        set_req(2, 1'b1, 32'h20, 32'h0, 4'h0, 1'b1);
        to_sample();
        for (int g = 0; g < NI; g++) chk($sformatf("i%0d_ax_rd_gnt", g), winner(g), 2);
        to_drive();
        idle_all();
        to_sample();
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("i%0d_raw_ax_rsp_val", g), 32'(rsp_val_o[g][2]), 1);
            chk($sformatf("i%0d_raw_ax_rdat", g), rdat_o[g][2], 32'h0000000F);
        end
        to_drive();

        // Illegal read+write request.
        set_req(0, 1'b1, 32'h21, 32'h12345678, 4'hF, 1'b1);
        to_sample();
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("i%0d_illegal_err", g), 32'(err_o[g]), 1);
            chk($sformatf("i%0d_illegal_sram_ren", g), 32'(sram_ren_o[g]), 0);
            chk($sformatf("i%0d_illegal_sram_wen", g), 32'(sram_wen_o[g]), 32'hF);
        end
        to_drive();
        idle_all();
        to_sample();
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("i%0d_illegal_no_rsp", g),
                32'(rsp_val_o[g][0]) + 32'(rsp_val_o[g][1]) + 32'(rsp_val_o[g][2]), 0);
            chk($sformatf("i%0d_err_one_cycle", g), 32'(err_o[g]), 0);
        end
        to_drive();

        // Reset while an if read response is pending.
        set_req(0, 1'b1, 32'h5, 32'h0, 4'h0, 1'b1);
        to_sample();
        for (int g = 0; g < NI; g++) chk($sformatf("i%0d_if_rd_gnt", g), winner(g), 0);
        to_drive();
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("i%0d_rst_if_rsp_val", g), 32'(rsp_val_o[g][0]), 0);
            chk($sformatf("i%0d_rst_if_rdat", g), rdat_o[g][0], 0);
            chk($sformatf("i%0d_rst_no_rdy", g), winner(g), -1);
            chk($sformatf("i%0d_rst_sram_adr", g), sram_adr_o[g], 0);
        end
        to_drive();
        to_drive();
        rst_n = 1'b1;
        idle_all();
        for (int n = 0; n < 3; n++) begin
            to_sample();
            for (int g = 0; g < NI; g++)
                chk($sformatf("i%0d_post_rst_if_quiet_%0d", g, n), 32'(rsp_val_o[g][0]), 0);
            to_drive();
        end
        set_req(0, 1'b1, 32'h5, 32'h0, 4'h0, 1'b1);
        to_sample();
        to_drive();
        idle_all();
        to_sample();
        for (int g = 0; g < NI; g++)
            chk($sformatf("i%0d_recover_if_rdat", g), rdat_o[g][0], init_word(5));
        to_drive();
        to_drive();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cirno9_sram_arb.md
# cirno9_sram_arb

Single-port SRAM arbiter for the cirno9 core: shares one synchronous SRAM between three requesters (instruction fetch, execute-stage load/store, AXI-slave bridge) using valid/ready request handshakes. Uses fixed priority with anti-starvation aging. Routes one-cycle-latency read data back to the requester that issued the read. Sits between the core's fetch/LSU paths and the SRAM macro, replacing ad-hoc port muxing.

## Interface
Parameters:
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.
- STARVE_MAX, 8, consecutive lost-arbitration cycles after which fetch or AXI becomes urgent; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- Per requester `X` in {if, ls, ax}:
  - hs_X4arb_val  in  1  request valid.
  - hs_arb4X_rdy  out  1  request accepted this cycle (grant).
  - i_X_adr  in  AW  word address.
  - i_X_wdat  in  DW  write data.
  - i_X_wen  in  DW/8  byte write enables.
  - i_X_ren  in  1  read enable.
  - o_X_rsp_val  out  1  read data valid.
  - o_X_rdat  out  DW  read data.
- o_sram_ren  out  1  SRAM read strobe.
- o_sram_wen  out  DW/8  SRAM byte write strobes.
- o_sram_adr  out  AW  SRAM address.
- o_sram_wdat  out  DW  SRAM write data.
- i_sram_rdat  in  DW  SRAM read data, valid the cycle after o_sram_ren.
- o_err  out  1  one-cycle pulse on an illegal granted request.

## Operation
- armed register: cleared by reset; set on the first clk edge after rst_n deasserts. No grants while armed=0.
- Grant selection:
  - At most one grant per cycle, chosen combinationally among valid requesters.
  - Priority: urgent ax > urgent if > ls > if > ax.
  - hs_arb4X_rdy is high only for the granted requester. A request completes on val&&rdy.
- Granted request drives the SRAM in the same cycle:
  - o_sram_adr = i_X_adr.
  - o_sram_wdat = i_X_wdat.
  - o_sram_wen = i_X_wen.
  - o_sram_ren = i_X_ren && (i_X_wen == 0).
- When no grant is made: o_sram_ren=0, o_sram_wen=0, o_sram_adr=0, o_sram_wdat=0.
- Granted request with ren=1 and wen!=0:
  - Executed as a write only; no response.
  - o_err pulses for that cycle.
- Granted request with ren=0 and wen=0: accepted as a NOP; no SRAM strobe, no response.
- Aging counters wait_if and wait_ax (8 bits each):
  - Cleared by reset.
  - Increment (saturating at STARVE_MAX) each cycle the requester is valid and not granted.
  - Cleared on the requester's grant, or in any cycle its val is low.
  - Requester is urgent when its counter == STARVE_MAX.
- Read return tracking:
  - rsp_pend and rsp_own (2 bits) are registered on each read grant.
  - Next cycle: o_<rsp_own>_rsp_val=1 and o_<rsp_own>_rdat=i_sram_rdat; all other rsp_val=0.
  - Requesters cannot stall responses.
- Non-owner o_X_rdat is 0.

## Timing
- Reset values: all rdy=0, all rsp_val=0, all rdat=0, SRAM strobes 0, o_err=0, counters 0, rsp_pend=0, armed=0.
- Grant: zero-cycle, combinational from val. Read data latency: exactly 1 cycle after grant.
- Back-to-back grants to any mix of requesters are allowed every cycle. Read-after-read from different requesters returns in grant order, one per cycle.
- Write followed by read to the same address on the next cycle returns the new data (SRAM write-first).
- Simultaneous urgency: when both are urgent, ax wins. if stays urgent (counter held at STARVE_MAX) and wins the next cycle unless a new urgent ax appears. ax cannot re-age within one cycle, so if is served no later than the cycle after.
- Reset mid-operation (rst_n low with rsp_pend=1): the pending response is discarded, no rsp_val is issued after reset, and all registers clear immediately (asynchronous).
- val dropped before grant: the request is withdrawn and its counter clears. There is no requirement for requesters to hold val.

## Test plan
- Reset release with all three val=1: no rdy in the first cycle (armed=0); ls granted on the 2nd edge and o_sram_* mirror the ls fields.
- ls read at adr 0x10, SRAM returns 0xDEADBEEF: one cycle later o_ls_rsp_val=1 and o_ls_rdat=0xDEADBEEF; o_if_rsp_val and o_ax_rsp_val stay 0.
- ls valid continuously, ax valid, STARVE_MAX=8: ax is granted on its 9th valid cycle; wait_ax then clears and ls resumes.
- ls, if and ax all continuously valid, STARVE_MAX=2: grant sequence ls, ls, ax, if, ls, ... with no requester waiting more than 3 cycles.
- if write 0x0000000F byte-enable 4'b0001 to adr 0x20, then ax read of 0x20 next cycle: o_ax_rdat=0x0000000F; an if request with ren=1 and wen=4'hF pulses o_err=1, o_sram_ren=0 and produces no response.
- Assert rst_n=0 in the cycle after an if read grant: o_if_rsp_val never rises and all outputs read 0 immediately.
